noc_wh_router: RTL and testbench

//   Parametrised 5-port 2D-mesh router: wormhole switching, per-input FIFOs, XY routing, round-robin output arbitration.

---
 rtl/noc_wh_router.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_noc_wh_router.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_wh_router.sv
// 5-port 2D-mesh wormhole router: per-input FIFOs, XY routing, round-robin
// output arbitration with packet locking, edge-port masking and drop counting.
module noc_wh_router #(
  parameter int         TDATA_W = 64,
  parameter int         DX_W    = 2,
  parameter int         DY_W    = 2,
  parameter int         CUR_X   = 0,
  parameter int         CUR_Y   = 0,
  parameter int         FIFO_D  = 4,
  parameter logic [4:0] PORT_EN = 5'b11111,
  parameter int         CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [4:0]               in_tvalid,
  output logic [4:0]               in_tready,
  input  logic [5*TDATA_W-1:0]     in_tdata,
  input  logic [5*(DX_W+DY_W)-1:0] in_tdest,
  input  logic [4:0]               in_tlast,
  output logic [4:0]               out_tvalid,
  input  logic [4:0]               out_tready,
  output logic [5*TDATA_W-1:0]     out_tdata,
  output logic [5*(DX_W+DY_W)-1:0] out_tdest,
  output logic [4:0]               out_tlast,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int NP = 5;
  localparam int DW = DX_W + DY_W;
  localparam int EW = TDATA_W + DW + 1;
  localparam int AW = $clog2(FIFO_D);

  localparam logic [DX_W-1:0] CX = DX_W'(CUR_X);
  localparam logic [DY_W-1:0] CY = DY_W'(CUR_Y);

  localparam logic [2:0] PORT_P = 3'd0;
  localparam logic [2:0] PORT_E = 3'd1;
  localparam logic [2:0] PORT_W = 3'd2;
  localparam logic [2:0] PORT_N = 3'd3;
  localparam logic [2:0] PORT_S = 3'd4;

  typedef enum logic [1:0] {
    ST_HEAD = 2'd0,
    ST_BODY = 2'd1,
    ST_DROP = 2'd2
  } in_state_t;

  function automatic logic [2:0] xy_route(input logic [DW-1:0] dest);
    logic [DX_W-1:0] x_v;
    logic [DY_W-1:0] y_v;
    x_v = dest[DX_W-1:0];
    y_v = dest[DW-1:DX_W];
    if (x_v > CX)      return PORT_E;
    else if (x_v < CX) return PORT_W;
    else if (y_v < CY) return PORT_N;
    else if (y_v > CY) return PORT_S;
    else               return PORT_P;
  endfunction

  function automatic logic port_en_at(input logic [2:0] p);
    logic [7:0] en_v;
    en_v = {3'b000, PORT_EN};
    return en_v[p];
  endfunction

  function automatic logic [2:0] next_port(input logic [2:0] p);
    return (p == 3'd4) ? 3'd0 : (p + 3'd1);
  endfunction

  // Input FIFO storage and pointers (one extra pointer bit distinguishes full from empty)
  logic [AW:0]    wr_ptr_r [NP];
  logic [AW:0]    rd_ptr_r [NP];
  logic [EW-1:0]  mem_r    [NP][FIFO_D];
  logic [EW-1:0]  head_s   [NP];
  logic [2:0]     route_s  [NP];
  logic [NP-1:0]  full_s, empty_s, push_s, pop_s, drop_s, req_s;
  logic [NP-1:0]  route_ok_s, gnt_in_s, head_last_s;

  in_state_t      st_r     [NP];
  in_state_t      st_nxt_s [NP];

  // Per-output lock, owner, round-robin pointer and release bubble
  logic [NP-1:0]  lock_r, lock_nxt_s, rel_r, rel_nxt_s;
  logic [NP-1:0]  gnt_v_s, fwd_s, can_load_s;
  logic [2:0]     owner_r     [NP];
  logic [2:0]     owner_nxt_s [NP];
  logic [2:0]     ptr_r       [NP];
  logic [2:0]     ptr_nxt_s   [NP];
  logic [2:0]     gnt_idx_s   [NP];
  logic [2:0]     src_s       [NP];
  logic [EW-1:0]  fwd_flit_s  [NP];

  logic [NP-1:0]      ovalid_r, olast_r;
  logic [TDATA_W-1:0] odata_r [NP];
  logic [DW-1:0]      odest_r [NP];

  logic [CNT_W-1:0]   drop_cnt_r;
  logic [2:0]         drop_n_s;
  logic [CNT_W:0]     drop_sum_s;

  // FIFO status, head-flit decode and per-input request/drop qualification
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      empty_s[p]     = (wr_ptr_r[p] == rd_ptr_r[p]);
      full_s[p]      = (wr_ptr_r[p][AW] != rd_ptr_r[p][AW]) &&
                       (wr_ptr_r[p][AW-1:0] == rd_ptr_r[p][AW-1:0]);
      in_tready[p]   = rst_n & PORT_EN[p] & ~full_s[p];
      push_s[p]      = in_tvalid[p] & in_tready[p];
      head_s[p]      = mem_r[p][rd_ptr_r[p][AW-1:0]];
      head_last_s[p] = head_s[p][EW-1];
      route_s[p]     = xy_route(head_s[p][TDATA_W +: DW]);
      route_ok_s[p]  = port_en_at(route_s[p]);
      req_s[p]       = (st_r[p] == ST_HEAD) & ~empty_s[p] & route_ok_s[p];
      drop_s[p]      = ~empty_s[p] &
                       (((st_r[p] == ST_HEAD) & ~route_ok_s[p]) | (st_r[p] == ST_DROP));
    end
  end

  // Output arbitration: locked outputs follow their owner, free ones pick round-robin
  always_comb begin
    logic [2:0] idx_v;
    logic       hit_v;
    idx_v      = 3'd0;
    hit_v      = 1'b0;
    gnt_v_s    = '0;
    fwd_s      = '0;
    can_load_s = '0;
    pop_s      = '0;
    gnt_in_s   = '0;
    for (int o = 0; o < NP; o++) begin
      gnt_idx_s[o]  = 3'd0;
      src_s[o]      = 3'd0;
      fwd_flit_s[o] = '0;
    end
    for (int o = 0; o < NP; o++) begin
      can_load_s[o] = ~ovalid_r[o] | out_tready[o];
      if (lock_r[o]) begin
        src_s[o] = owner_r[o];
        fwd_s[o] = ~empty_s[owner_r[o]] & can_load_s[o];
      end else if (!rel_r[o]) begin
        idx_v = ptr_r[o];
        for (int k = 0; k < NP; k++) begin
          hit_v        = ~gnt_v_s[o] & req_s[idx_v] & (route_s[idx_v] == 3'(o));
          gnt_idx_s[o] = hit_v ? idx_v : gnt_idx_s[o];
          gnt_v_s[o]   = gnt_v_s[o] | hit_v;
          idx_v        = next_port(idx_v);
        end
        src_s[o] = gnt_idx_s[o];
        fwd_s[o] = gnt_v_s[o] & can_load_s[o];
      end else begin
        src_s[o] = 3'd0;
        fwd_s[o] = 1'b0;
      end
      fwd_flit_s[o]            = head_s[src_s[o]];
      pop_s[src_s[o]]          = pop_s[src_s[o]] | fwd_s[o];
      gnt_in_s[gnt_idx_s[o]]   = gnt_in_s[gnt_idx_s[o]] | gnt_v_s[o];
    end
    pop_s = pop_s | drop_s;
  end

  // Input packet FSM next state
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      st_nxt_s[i] = st_r[i];
      case (st_r[i])
        ST_HEAD: begin
          if (drop_s[i]) begin
            st_nxt_s[i] = head_last_s[i] ? ST_HEAD : ST_DROP;
          end else if (gnt_in_s[i]) begin
            st_nxt_s[i] = (pop_s[i] & head_last_s[i]) ? ST_HEAD : ST_BODY;
          end else begin
            st_nxt_s[i] = ST_HEAD;
          end
        end
        ST_BODY: st_nxt_s[i] = (pop_s[i] & head_last_s[i]) ? ST_HEAD : ST_BODY;
        ST_DROP: st_nxt_s[i] = (pop_s[i] & head_last_s[i]) ? ST_HEAD : ST_DROP;
        default: st_nxt_s[i] = ST_HEAD;
      endcase
    end
  end

  // Output lock next state; releasing on tlast forces one idle arbitration cycle
  always_comb begin
    logic last_v;
    last_v = 1'b0;
    for (int o = 0; o < NP; o++) begin
      lock_nxt_s[o]  = lock_r[o];
      rel_nxt_s[o]   = 1'b0;
      owner_nxt_s[o] = owner_r[o];
      ptr_nxt_s[o]   = ptr_r[o];
      last_v         = fwd_s[o] & fwd_flit_s[o][EW-1];
      if (lock_r[o]) begin
        lock_nxt_s[o] = ~last_v;
        rel_nxt_s[o]  = last_v;
      end else if (gnt_v_s[o]) begin
        owner_nxt_s[o] = gnt_idx_s[o];
        ptr_nxt_s[o]   = next_port(gnt_idx_s[o]);
        lock_nxt_s[o]  = ~last_v;
        rel_nxt_s[o]   = last_v;
      end else begin
        lock_nxt_s[o] = 1'b0;
        rel_nxt_s[o]  = 1'b0;
      end
    end
  end

  // Saturating drop counter increment
  always_comb begin
    drop_n_s = 3'd0;
    for (int p = 0; p < NP; p++) begin
      drop_n_s = drop_n_s + {2'b00, drop_s[p]};
    end
    drop_sum_s = {1'b0, drop_cnt_r} + (CNT_W+1)'(drop_n_s);
  end

  // FIFO payload write
  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (push_s[p]) begin
        mem_r[p][wr_ptr_r[p][AW-1:0]] <= {in_tlast[p], in_tdest[p*DW +: DW],
                                          in_tdata[p*TDATA_W +: TDATA_W]};
      end
    end
  end

  // FIFO pointers and input FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) begin
        wr_ptr_r[p] <= '0;
        rd_ptr_r[p] <= '0;
        st_r[p]     <= ST_HEAD;
      end
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (push_s[p]) wr_ptr_r[p] <= wr_ptr_r[p] + {{AW{1'b0}}, 1'b1};
        if (pop_s[p])  rd_ptr_r[p] <= rd_ptr_r[p] + {{AW{1'b0}}, 1'b1};
        st_r[p] <= st_nxt_s[p];
      end
    end
  end

  // Output lock, owner and round-robin pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_r <= '0;
      rel_r  <= '0;
      for (int o = 0; o < NP; o++) begin
        owner_r[o] <= 3'd0;
        ptr_r[o]   <= 3'd0;
      end
    end else begin
      lock_r <= lock_nxt_s;
      rel_r  <= rel_nxt_s;
      for (int o = 0; o < NP; o++) begin
        owner_r[o] <= owner_nxt_s[o];
        ptr_r[o]   <= ptr_nxt_s[o];
      end
    end
  end

  // Output register stage: loads when empty or drained this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovalid_r <= '0;
      olast_r  <= '0;
      for (int o = 0; o < NP; o++) begin
        odata_r[o] <= '0;
        odest_r[o] <= '0;
      end
    end else begin
      for (int o = 0; o < NP; o++) begin
        if (fwd_s[o]) begin
          ovalid_r[o] <= 1'b1;
          odata_r[o]  <= fwd_flit_s[o][TDATA_W-1:0];
          odest_r[o]  <= fwd_flit_s[o][TDATA_W +: DW];
          olast_r[o]  <= fwd_flit_s[o][EW-1];
        end else if (out_tready[o]) begin
          ovalid_r[o] <= 1'b0;
        end
      end
    end
  end

  // Drop counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r <= '0;
    end else if (drop_sum_s[CNT_W]) begin
      drop_cnt_r <= '1;
    end else begin
      drop_cnt_r <= drop_sum_s[CNT_W-1:0];
    end
  end

  // Output packing; masked ports never present a valid flit
  always_comb begin
    for (int o = 0; o < NP; o++) begin
      out_tvalid[o]                   = ovalid_r[o] & PORT_EN[o];
      out_tlast[o]                    = olast_r[o];
      out_tdata[o*TDATA_W +: TDATA_W] = odata_r[o];
      out_tdest[o*DW +: DW]           = odest_r[o];
    end
    drop_cnt = drop_cnt_r;
  end

endmodule

// File: tb/tb_noc_wh_router.sv
// Directed bench for noc_wh_router: routing vector table plus multi-cycle
// sequences for packet order, arbitration, backpressure, masking and reset.
module tb_noc_wh_router;

  localparam int TW = 64;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    in_tvalid, in_tready, in_tlast, out_tvalid, out_tready, out_tlast;
  logic [5*TW-1:0] in_tdata, out_tdata;
  logic [5*DW-1:0] in_tdest, out_tdest;
  logic [15:0]   drop_cnt;

  logic [4:0]    m_in_tvalid, m_in_tready, m_in_tlast, m_out_tvalid, m_out_tready, m_out_tlast;
  logic [5*TW-1:0] m_in_tdata, m_out_tdata;
  logic [5*DW-1:0] m_in_tdest, m_out_tdest;
  logic [15:0]   m_drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  noc_wh_router #(.CUR_X(1), .CUR_Y(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
    .in_tdest(in_tdest), .in_tlast(in_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
    .out_tdest(out_tdest), .out_tlast(out_tlast), .drop_cnt(drop_cnt)
  );

  noc_wh_router #(.CUR_X(0), .CUR_Y(0), .PORT_EN(5'b01011)) dut_m (
    .clk(clk), .rst_n(rst_n),
    .in_tvalid(m_in_tvalid), .in_tready(m_in_tready), .in_tdata(m_in_tdata),
    .in_tdest(m_in_tdest), .in_tlast(m_in_tlast),
    .out_tvalid(m_out_tvalid), .out_tready(m_out_tready), .out_tdata(m_out_tdata),
    .out_tdest(m_out_tdest), .out_tlast(m_out_tlast), .drop_cnt(m_drop_cnt)
  );

  typedef struct packed {
    logic [2:0] src;
    logic [3:0] dest;
    logic [2:0] eo;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic [63:0] d, input logic [3:0] dst, input logic lst);
    in_tvalid[p]         = 1'b1;
    in_tdata[p*TW +: TW] = d;
    in_tdest[p*DW +: DW] = dst;
    in_tlast[p]          = lst;
  endtask

  task automatic clear_inputs();
    in_tvalid = 5'b00000; in_tlast = 5'b00000; in_tdata = '0; in_tdest = '0;
    m_in_tvalid = 5'b00000; m_in_tlast = 5'b00000; m_in_tdata = '0; m_in_tdest = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sent, rcv;
    logic seen_v;
    rst_n = 1'b0;
    clear_inputs();
    out_tready   = 5'b11111;
    m_out_tready = 5'b11111;

    vecs[0]  = '{3'd0, 4'b0101, 3'd0};
    vecs[1]  = '{3'd0, 4'b0110, 3'd1};
    vecs[2]  = '{3'd0, 4'b0100, 3'd2};
    vecs[3]  = '{3'd0, 4'b0001, 3'd3};
    vecs[4]  = '{3'd0, 4'b1101, 3'd4};
    vecs[5]  = '{3'd1, 4'b1111, 3'd1};
    vecs[6]  = '{3'd2, 4'b0000, 3'd2};
    vecs[7]  = '{3'd3, 4'b0010, 3'd1};
    vecs[8]  = '{3'd4, 4'b1100, 3'd2};
    vecs[9]  = '{3'd3, 4'b1001, 3'd4};
    vecs[10] = '{3'd4, 4'b0001, 3'd3};
    vecs[11] = '{3'd1, 4'b0101, 3'd0};
    vecs[12] = '{3'd2, 4'b0011, 3'd1};

    // reset state
    step();
    chk("rst_out_tvalid", 64'(out_tvalid), 64'(5'b00000));
    chk("rst_in_tready", 64'(in_tready), 64'(5'b00000));
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_m_drop_cnt", 64'(m_drop_cnt), 64'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_tready", 64'(in_tready), 64'(5'b11111));
    chk("post_rst_m_in_tready", 64'(m_in_tready), 64'(5'b01011));
    chk("post_rst_out_tvalid", 64'(out_tvalid), 64'(5'b00000));

    // routing table: single-flit packets, output two edges after acceptance
    for (int i = 0; i < 13; i++) begin
      int s, e;
      s = int'(vecs[i].src);
      e = int'(vecs[i].eo);
      drive(s, 64'hD000 + 64'(i), vecs[i].dest, 1'b1);
      step();
      in_tvalid = 5'b00000;
      in_tlast  = 5'b00000;
      chk($sformatf("vec%0d_early", i), 64'(out_tvalid), 64'(5'b00000));
      step();
      chk($sformatf("vec%0d_valid", i), 64'(out_tvalid), 64'(5'b00001 << e));
      chk($sformatf("vec%0d_data", i), out_tdata[e*TW +: TW], 64'hD000 + 64'(i));
      chk($sformatf("vec%0d_dest", i), 64'(out_tdest[e*DW +: DW]), 64'(vecs[i].dest));
      chk($sformatf("vec%0d_last", i), 64'(out_tlast[e]), 64'd1);
      step();
      step();
    end
    chk("table_drop_cnt", 64'(drop_cnt), 64'd0);

    // 4-flit packet P -> E, in order, tlast on the 4th
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c < 4) drive(0, 64'h100 + 64'(c), 4'b0111, (c == 3));
      else in_tvalid = 5'b00000;
      step();
      if (c >= 1 && c <= 4) begin
        chk($sformatf("t1_valid%0d", c), 64'(out_tvalid), 64'(5'b00010));
        chk($sformatf("t1_data%0d", c), out_tdata[1*TW +: TW], 64'h100 + 64'(c - 1));
        chk($sformatf("t1_last%0d", c), 64'(out_tlast[1]), 64'((c == 4) ? 1 : 0));
      end else begin
        chk($sformatf("t1_idle%0d", c), 64'(out_tvalid), 64'(5'b00000));
      end
    end

    // W and N contend for P: W first, one bubble, then N
    do_reset();
    for (int c = 0; c < 9; c++) begin
      if (c < 3) begin
        drive(2, 64'hA0 + 64'(c), 4'b0101, (c == 2));
        drive(3, 64'hB0 + 64'(c), 4'b0101, (c == 2));
      end else begin
        in_tvalid = 5'b00000;
      end
      step();
      if (c >= 1 && c <= 3) begin
        chk($sformatf("t2_valid%0d", c), 64'(out_tvalid), 64'(5'b00001));
        chk($sformatf("t2_data%0d", c), out_tdata[0 +: TW], 64'hA0 + 64'(c - 1));
        chk($sformatf("t2_last%0d", c), 64'(out_tlast[0]), 64'((c == 3) ? 1 : 0));
      end else if (c >= 5 && c <= 7) begin
        chk($sformatf("t2_valid%0d", c), 64'(out_tvalid), 64'(5'b00001));
        chk($sformatf("t2_data%0d", c), out_tdata[0 +: TW], 64'hB0 + 64'(c - 5));
        chk($sformatf("t2_last%0d", c), 64'(out_tlast[0]), 64'((c == 7) ? 1 : 0));
      end else begin
        chk($sformatf("t2_gap%0d", c), 64'(out_tvalid), 64'(5'b00000));
      end
    end

    // S stalled 10 cycles, 8-flit packet from P
    do_reset();
    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
      logic acc_v, tx_v;
      if (cyc == 10) begin
        chk("t3_accepted", 64'(sent), 64'd5);
        chk("t3_in_tready", 64'(in_tready[0]), 64'd0);
        chk("t3_hold_valid", 64'(out_tvalid[4]), 64'd1);
        chk("t3_hold_data", out_tdata[4*TW +: TW], 64'h300);
      end
      out_tready[4] = (cyc >= 10);
      if (sent < 8) drive(0, 64'h300 + 64'(sent), 4'b1101, (sent == 7));
      else in_tvalid = 5'b00000;
      #1;
      acc_v = in_tvalid[0] & in_tready[0];
      tx_v  = out_tvalid[4] & out_tready[4];
      if (tx_v) begin
        chk($sformatf("t3_data%0d", rcv), out_tdata[4*TW +: TW], 64'h300 + 64'(rcv));
        chk($sformatf("t3_last%0d", rcv), 64'(out_tlast[4]), 64'((rcv == 7) ? 1 : 0));
      end
      step();
      if (acc_v) sent++;
      if (tx_v) rcv++;
    end
    in_tvalid = 5'b00000;
    chk("t3_received", 64'(rcv), 64'd8);
    out_tready = 5'b11111;
    step();
    chk("t3_drained", 64'(out_tvalid), 64'(5'b00000));

    // masked S on the edge node: packet dropped and counted, next one delivered
    do_reset();
    seen_v = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c < 3) begin
        m_in_tvalid[0]       = 1'b1;
        m_in_tdata[0 +: TW]  = 64'h400 + 64'(c);
        m_in_tdest[0 +: DW]  = 4'b1000;
        m_in_tlast[0]        = (c == 2);
      end else begin
        m_in_tvalid = 5'b00000;
      end
      step();
      seen_v = seen_v | (|m_out_tvalid);
    end
    chk("t4_no_valid", 64'(seen_v), 64'd0);
    chk("t4_drop_cnt", 64'(m_drop_cnt), 64'd3);
    m_in_tvalid[0]      = 1'b1;
    m_in_tdata[0 +: TW] = 64'h4F0;
    m_in_tdest[0 +: DW] = 4'b0000;
    m_in_tlast[0]       = 1'b1;
    step();
    m_in_tvalid = 5'b00000;
    step();
    chk("t4_next_valid", 64'(m_out_tvalid), 64'(5'b00001));
    chk("t4_next_data", m_out_tdata[0 +: TW], 64'h4F0);
    chk("t4_drop_stable", 64'(m_drop_cnt), 64'd3);

    // asynchronous reset mid-packet on E, then normal routing
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(0, 64'h500 + 64'(c), 4'b0111, 1'b0);
      step();
    end
    chk("t5_pre_valid", 64'(out_tvalid), 64'(5'b00010));
    chk("t5_pre_data", out_tdata[1*TW +: TW], 64'h501);
    rst_n = 1'b0;
    in_tvalid = 5'b00000;
    #1;
    chk("t5_async_valid", 64'(out_tvalid), 64'(5'b00000));
    chk("t5_async_ready", 64'(in_tready), 64'(5'b00000));
    step();
    rst_n = 1'b1;
    step();
    chk("t5_rel_ready", 64'(in_tready), 64'(5'b11111));
    chk("t5_rel_valid", 64'(out_tvalid), 64'(5'b00000));
    drive(0, 64'h5A0, 4'b0111, 1'b0);
    step();
    chk("t5_new_early", 64'(out_tvalid), 64'(5'b00000));
    drive(0, 64'h5A1, 4'b0111, 1'b1);
    step();
    in_tvalid = 5'b00000;
    chk("t5_new_f0", out_tdata[1*TW +: TW], 64'h5A0);
    chk("t5_new_v0", 64'(out_tvalid), 64'(5'b00010));
    step();
    chk("t5_new_f1", out_tdata[1*TW +: TW], 64'h5A1);
    chk("t5_new_l1", 64'(out_tlast[1]), 64'd1);

    // single-flit local packet from N
    do_reset();
    drive(3, 64'h600, 4'b0101, 1'b1);
    step();
    in_tvalid = 5'b00000;
    chk("t6_early", 64'(out_tvalid), 64'(5'b00000));
    step();
    chk("t6_valid", 64'(out_tvalid), 64'(5'b00001));
    chk("t6_data", out_tdata[0 +: TW], 64'h600);
    chk("t6_last", 64'(out_tlast[0]), 64'd1);
    step();
    chk("t6_after", 64'(out_tvalid), 64'(5'b00000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
